// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipeline_hazard_ctrl.
//
// Ports grouped here:
//   id_rs1, id_rs2   ID-stage source register indices            (datapath -> ctrl)
//   ex_rd            EX-stage destination register index         (datapath -> ctrl)
//   ex_mem_read      EX-stage instruction is a load              (datapath -> ctrl)
//   ex_branch_taken  taken branch/jump resolved in EX            (datapath -> ctrl)
//   imem_ready       instruction memory returns a word this cycle(datapath -> ctrl)
//   pc_write, if_id_write, if_id_flush, id_ex_flush              (ctrl -> datapath)
//   imem_timeout     sticky instruction-fetch timeout            (ctrl -> datapath)
//   load_use_cnt, flush_cnt, miss_cnt  performance counters      (ctrl -> datapath)
//
// Modports: master = datapath side, slave = hazard controller side.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             imem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             imem_timeout;
  logic [CNT_W-1:0] load_use_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] miss_cnt;

  modport master (
    output id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken, imem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, imem_timeout,
    input  load_use_cnt, flush_cnt, miss_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken, imem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, imem_timeout,
    output load_use_cnt, flush_cnt, miss_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: resolves branch flushes, load-use stalls and
// instruction-fetch misses, tracks a stale in-flight fetch after a branch taken
// during a miss (DROP state), flags a sticky fetch timeout and optionally keeps
// performance counters.
//
// Ports:
//   clk    clock, all state on rising edge
//   reset  synchronous, active-high reset
//   hz     pipeline_hazard_ctrl_if.slave bundle (hazard inputs, control outputs,
//          imem_timeout, performance counters)
//
// Parameters:
//   CNT_W         width of each performance counter (must match the interface)
//   MISS_TIMEOUT  consecutive imem miss cycles before timeout, 2..255
//
// Build option: define HAZARD_PERF_CNT_EN to enable the performance counters;
// otherwise the counter outputs are tied to zero and no counter flops exist.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned MISS_TIMEOUT = 64
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [7:0] MissMax = 8'(MISS_TIMEOUT);

  typedef enum logic [0:0] {StRun, StDrop} state_e;

  state_e     state_q, state_d;
  logic [7:0] miss_q, miss_d;
  logic       timeout_q;
  logic       load_use;
  logic       load_use_evt;
  logic       flush_evt;

  assign load_use = hz.ex_mem_read & (hz.ex_rd != 5'd0) &
                    ((hz.ex_rd == hz.id_rs1) | (hz.ex_rd == hz.id_rs2));

  // Control outputs and next state. Defaults are the reset/bubble values.
  always_comb begin
    hz.pc_write    = 1'b0;
    hz.if_id_write = 1'b0;
    hz.if_id_flush = 1'b1;
    hz.id_ex_flush = 1'b1;
    state_d        = state_q;
    load_use_evt   = 1'b0;
    flush_evt      = 1'b0;
    if (reset) begin
      state_d = StRun;
    end else if (hz.ex_branch_taken) begin
      hz.pc_write = 1'b1;
      flush_evt   = 1'b1;
      // A branch during a miss leaves a wrong-path fetch in flight; drop it.
      state_d     = hz.imem_ready ? StRun : StDrop;
    end else begin
      // Any returned word ends a pending drop, whatever else happens.
      if (hz.imem_ready) state_d = StRun;
      if (load_use) begin
        hz.if_id_flush = 1'b0;
        load_use_evt   = 1'b1;
      end else if (!hz.imem_ready) begin
        hz.id_ex_flush = 1'b0;
      end else if (state_q == StDrop) begin
        // Stale word returned: discard it and refetch.
        hz.id_ex_flush = 1'b0;
        flush_evt      = 1'b1;
      end else begin
        hz.pc_write    = 1'b1;
        hz.if_id_write = 1'b1;
        hz.if_id_flush = 1'b0;
        hz.id_ex_flush = 1'b0;
      end
    end
  end

  // Consecutive-miss counter, saturating at the timeout threshold.
  always_comb begin
    miss_d = miss_q;
    if (hz.imem_ready) begin
      miss_d = 8'd0;
    end else if (miss_q != MissMax) begin
      miss_d = miss_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StRun;
      miss_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
      if (miss_d == MissMax) timeout_q <= 1'b1;
    end
  end

  assign hz.imem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0] load_use_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      load_use_cnt_q <= '0;
      flush_cnt_q    <= '0;
      miss_cnt_q     <= '0;
    end else begin
      if (load_use_evt && load_use_cnt_q != CntMax) load_use_cnt_q <= load_use_cnt_q + CntOne;
      if (flush_evt && flush_cnt_q != CntMax)       flush_cnt_q    <= flush_cnt_q + CntOne;
      if (!hz.imem_ready && miss_cnt_q != CntMax)   miss_cnt_q     <= miss_cnt_q + CntOne;
    end
  end

  assign hz.load_use_cnt = load_use_cnt_q;
  assign hz.flush_cnt    = flush_cnt_q;
  assign hz.miss_cnt     = miss_cnt_q;
`else
  logic unused_evt;
  assign unused_evt      = load_use_evt ^ flush_evt;
  assign hz.load_use_cnt = '0;
  assign hz.flush_cnt    = '0;
  assign hz.miss_cnt     = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W        = 2;
  localparam int unsigned MISS_TIMEOUT = 4;
  localparam int          CNT_SAT      = (1 << CNT_W) - 1;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(
    .CNT_W       (CNT_W),
    .MISS_TIMEOUT(MISS_TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit model_live = 1'b0;
  bit m_drop     = 1'b0;  // a wrong-path fetch is still outstanding
  int m_miss     = 0;
  bit m_to       = 1'b0;
  int m_lu       = 0;
  int m_fl       = 0;
  int m_ms       = 0;

  function automatic bit is_load_use();
    return hz.ex_mem_read && hz.ex_rd != 0 && (hz.ex_rd == hz.id_rs1 || hz.ex_rd == hz.id_rs2);
  endfunction

  function automatic int sat_inc(input int v);
    return (v < CNT_SAT) ? v + 1 : v;
  endfunction

  // {pc_write, if_id_write, if_id_flush, id_ex_flush}
  function automatic logic [3:0] model_ctrl();
    if (reset)                      return 4'b0011;
    if (hz.ex_branch_taken)         return 4'b1011;
    if (is_load_use())              return 4'b0001;
    if (!hz.imem_ready || m_drop)   return 4'b0010;
    return 4'b1100;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      model_live = 1'b1;
      m_drop = 1'b0; m_miss = 0; m_to = 1'b0; m_lu = 0; m_fl = 0; m_ms = 0;
    end else begin
      if (hz.ex_branch_taken) begin
        m_fl   = sat_inc(m_fl);
        m_drop = !hz.imem_ready;
      end else begin
        if (is_load_use()) m_lu = sat_inc(m_lu);
        else if (m_drop && hz.imem_ready) m_fl = sat_inc(m_fl);
        if (hz.imem_ready) m_drop = 1'b0;
      end
      if (hz.imem_ready) begin
        m_miss = 0;
      end else begin
        m_ms   = sat_inc(m_ms);
        m_miss = (m_miss < MISS_TIMEOUT) ? m_miss + 1 : m_miss;
      end
      if (m_miss == MISS_TIMEOUT) m_to = 1'b1;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      chk("ctrl", {hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_ex_flush}, model_ctrl());
      chk("imem_timeout", hz.imem_timeout, m_to);
      chk("load_use_cnt", hz.load_use_cnt, PERF ? m_lu : 0);
      chk("flush_cnt", hz.flush_cnt, PERF ? m_fl : 0);
      chk("miss_cnt", hz.miss_cnt, PERF ? m_ms : 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd0; hz.ex_rd = 5'd0;
    hz.ex_mem_read = 1'b0; hz.ex_branch_taken = 1'b0; hz.imem_ready = 1'b1;
  endtask

  task automatic ctrl_is(input string name, input logic [3:0] exp);
    @(negedge clk);
    chk(name, {hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_ex_flush}, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd3; hz.id_rs1 = 5'd3;  // inputs must be ignored
    ctrl_is("reset_ctrl", 4'b0011);
    tick();
    reset = 1'b0;
    idle();
    chk("reset_timeout", hz.imem_timeout, 0);
    chk("reset_lu_cnt", hz.load_use_cnt, 0);
    chk("reset_fl_cnt", hz.flush_cnt, 0);
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    hz.ex_mem_read = 1'b1; hz.ex_rd = rd; hz.id_rs1 = 5'd1; hz.id_rs2 = 5'd5;
  endtask

  int exp37[5];

  initial begin
    idle();
    #1;
    do_reset();

    // Load-use on rs2.
    set_load_use(5'd5);
    ctrl_is("lu_ctrl", 4'b0001);
    tick();
    chk("lu_cnt_1", hz.load_use_cnt, PERF ? 1 : 0);

    // Destination x0 never creates a hazard.
    set_load_use(5'd0);
    ctrl_is("x0_ctrl", 4'b1100);
    tick();
    chk("x0_cnt", hz.load_use_cnt, PERF ? 1 : 0);

    // Branch wins over load-use.
    set_load_use(5'd5);
    hz.ex_branch_taken = 1'b1;
    ctrl_is("br_lu_ctrl", 4'b1011);
    tick();
    chk("br_lu_cnt", hz.load_use_cnt, PERF ? 1 : 0);
    chk("br_fl_cnt", hz.flush_cnt, PERF ? 1 : 0);

    // Branch during a miss, drop the stale word.
    do_reset();
    hz.imem_ready = 1'b0;
    ctrl_is("miss_ctrl", 4'b0010);
    tick();
    hz.ex_branch_taken = 1'b1;
    ctrl_is("drop_br_ctrl", 4'b1011);
    tick();
    hz.ex_branch_taken = 1'b0;
    ctrl_is("drop_wait1", 4'b0010);
    tick();
    ctrl_is("drop_wait2", 4'b0010);
    tick();
    hz.imem_ready = 1'b1;
    ctrl_is("drop_stale", 4'b0010);
    tick();
    ctrl_is("drop_exit_run", 4'b1100);
    chk("drop_fl_cnt", hz.flush_cnt, PERF ? 2 : 0);
    tick();

    // Fetch timeout after MISS_TIMEOUT consecutive misses.
    do_reset();
    hz.imem_ready = 1'b0;
    tick(); tick(); tick();
    chk("to_after3", hz.imem_timeout, 0);
    tick();
    chk("to_after4", hz.imem_timeout, 1);
    hz.imem_ready = 1'b1;
    tick();
    chk("to_sticky", hz.imem_timeout, 1);
    do_reset();
    chk("to_cleared", hz.imem_timeout, 0);

    // Counter saturation.
    exp37 = '{1, 2, 3, 3, 3};
    set_load_use(5'd5);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("lu_sat", hz.load_use_cnt, PERF ? exp37[i] : 0);
    end
    idle();
    tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset              = ($urandom_range(0, 199) == 0);
      hz.id_rs1          = 5'($urandom_range(0, 3));
      hz.id_rs2          = 5'($urandom_range(0, 3));
      hz.ex_rd           = 5'($urandom_range(0, 3));
      hz.ex_mem_read     = ($urandom_range(0, 1) == 1);
      hz.ex_branch_taken = ($urandom_range(0, 7) == 0);
      hz.imem_ready      = ($urandom_range(0, 9) < 6);
      tick();
    end
    reset = 1'b0;
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter CNT_W, 16, SHALL set the width of each performance counter.
REQ-002 Parameter MISS_TIMEOUT, 64, SHALL set the consecutive imem-miss cycles before timeout; legal range 2..255.
REQ-003 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 id_rs1, id_rs2  input  5 each  SHALL carry the ID-stage source register indices.
REQ-006 ex_rd  input  5  SHALL carry the EX-stage destination register index.
REQ-007 ex_mem_read  input  1  SHALL flag that the EX-stage instruction is a load.
REQ-008 ex_branch_taken  input  1  SHALL flag a resolved taken branch/jump in EX.
REQ-009 imem_ready  input  1  SHALL flag that instruction memory returns a valid word this cycle.
REQ-010 pc_write  output  1  SHALL enable the PC update.
REQ-011 if_id_write  output  1  SHALL enable the IF/ID register load.
REQ-012 if_id_flush  output  1  SHALL zero the IF/ID register (bubble).
REQ-013 id_ex_flush  output  1  SHALL zero the ID/EX control fields (bubble).
REQ-014 imem_timeout  output  1  SHALL flag a sticky instruction-fetch timeout.
REQ-015 load_use_cnt, flush_cnt, miss_cnt  output  CNT_W each  SHALL report performance counts.

Function
REQ-016 States SHALL be RUN and DROP; four control outputs combinational from state and inputs, all else registered.
REQ-017 load_use SHALL be ex_mem_read & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
REQ-018 Priority SHALL be: branch > load_use > miss > normal.
REQ-019 Branch (any state): pc_write=1, if_id_write=0, if_id_flush=1, id_ex_flush=1; next state DROP if imem_ready=0, else RUN.
REQ-020 Load_use, no branch: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_flush=1 (hold IF/ID, one bubble into EX).
REQ-021 Miss (imem_ready=0), no branch/load_use: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=0.
REQ-022 Normal in RUN: pc_write=1, if_id_write=1, both flushes 0.
REQ-023 DROP, no branch, imem_ready=1: returned word is stale; pc_write=0, if_id_write=0, if_id_flush=1; next state RUN.
REQ-024 DROP, no branch, imem_ready=0: outputs per miss rule; remain in DROP.
REQ-025 Load_use in DROP SHALL still assert id_ex_flush=1 and hold IF/ID; DROP exit rule unchanged.
REQ-026 Miss counter SHALL count consecutive imem_ready=0 cycles, clear on imem_ready=1, saturate at MISS_TIMEOUT.
REQ-027 imem_timeout SHALL set on the edge where the miss counter reaches MISS_TIMEOUT and stay 1 until reset.

Reset
REQ-028 While reset=1: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1 regardless of inputs.
REQ-029 On reset edge: state RUN, miss counter 0, imem_timeout 0, all performance counters 0; reset mid-DROP discards the pending drop.

Configuration
REQ-030 With HAZARD_PERF_CNT_EN defined: load_use_cnt +1 per REQ-020 cycle, flush_cnt +1 per REQ-019 or REQ-023 cycle, miss_cnt +1 per imem_ready=0 cycle (reset excluded); each saturates at 2^CNT_W-1.
REQ-031 Without HAZARD_PERF_CNT_EN: the three counter outputs SHALL be constant 0 and no counter flops SHALL exist.

Verification
REQ-032 ex_mem_read=1, ex_rd=5, id_rs2=5, imem_ready=1 one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0; load_use_cnt 0->1.
REQ-033 Same as REQ-032 with ex_rd=0 -> normal outputs (1,1,0,0); no count.
REQ-034 ex_branch_taken=1 with load_use true -> pc_write=1, both flushes 1, if_id_write=0; load_use_cnt unchanged.
REQ-035 imem_ready=0, branch 1 cycle, imem_ready=0 two more cycles, then 1 -> state DROP; on ready cycle if_id_flush=1, pc_write=0; next cycle RUN with (1,1,0,0); flush_cnt +2.
REQ-036 MISS_TIMEOUT=4, imem_ready=0 for 4 cycles -> imem_timeout=1 after 4th edge, stays 1 after imem_ready=1; reset clears it.
REQ-037 CNT_W=2, 5 load_use cycles with macro defined -> load_use_cnt sequence 1,2,3,3,3.
